// File: rtl/lpc_pkg.sv
// rtl/lpc_pkg.sv - LPC capture record layout, cycle type codes and capture FSM states
package lpc_pkg;

  localparam int LPC_REC_ADDR_LSB = 12;
  localparam int LPC_REC_ADDR_W   = 16;
  localparam int LPC_REC_DATA_LSB = 4;
  localparam int LPC_REC_DATA_W   = 8;
  localparam int LPC_REC_TYPE_LSB = 0;
  localparam int LPC_REC_TYPE_W   = 2;

  localparam logic [1:0] LPC_CYC_NONE = 2'b00;
  localparam logic [1:0] LPC_CYC_WR   = 2'b01;
  localparam logic [1:0] LPC_CYC_RD   = 2'b11;

  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_HOLD = 1'b1
  } cap_state_e;

  function automatic logic lpc_win_hit(input logic [15:0] addr,
                                       input logic [15:0] base,
                                       input logic [15:0] mask);
    return ((addr ^ base) & mask) == 16'h0000;
  endfunction

endpackage

// File: rtl/lpc_sync_fifo.sv
// rtl/lpc_sync_fifo.sv - first-word-fall-through FIFO with same-cycle push/pop and flush
module lpc_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

  // A pop frees the slot, so a push into a full FIFO still lands when paired with one.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Head is forced to zero when empty so the output never shows stale storage.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/lpc_cycle_capture_ctrl.sv
// rtl/lpc_cycle_capture_ctrl.sv - LPC address window decode and filtered cycle record capture
module lpc_cycle_capture_ctrl
  import lpc_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic [15:0]              win_base_i,
  input  logic [15:0]              win_mask_i,
  input  logic [15:0]              lpc_addr_i,
  output logic                     addr_hit_o,
  input  logic [31:0]              tdata_i,
  input  logic                     ready_i,
  output logic [31:0]              m_tdata_o,
  output logic                     m_tvalid_o,
  input  logic                     m_tready_i,
  input  logic                     clr_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  output logic [7:0]               drop_cnt_o
);

  cap_state_e  state_q, state_d;
  logic        ready_prev_q, ready_prev_d;
  logic        addr_hit_q, addr_hit_d;
  logic        overflow_q, overflow_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic        eval;
  logic        push_req;
  logic        pop;
  logic        drop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [1:0]  rec_type;
  logic [15:0] rec_addr;

  assign rec_type = tdata_i[LPC_REC_TYPE_LSB +: LPC_REC_TYPE_W];
  assign rec_addr = tdata_i[LPC_REC_ADDR_LSB +: LPC_REC_ADDR_W];

  assign m_tvalid_o = !fifo_empty;
  assign pop        = m_tvalid_o && m_tready_i;
  assign push_req   = eval && en_i && (rec_type != LPC_CYC_NONE) &&
                      lpc_win_hit(rec_addr, win_base_i, win_mask_i);
  assign drop       = push_req && fifo_full && !pop && !clr_i;

  // ready_prev_q resets high so a READY already asserted at reset release is not
  // mistaken for a new record; a fresh low-to-high transition is required.
  always_comb begin
    state_d      = state_q;
    eval         = 1'b0;
    ready_prev_d = ready_i;
    case (state_q)
      CAP_IDLE: begin
        if (ready_i) begin
          state_d = CAP_HOLD;
          eval    = !ready_prev_q;
        end
      end
      CAP_HOLD: begin
        if (!ready_i) state_d = CAP_IDLE;
      end
      default: state_d = CAP_IDLE;
    endcase
  end

  always_comb begin
    addr_hit_d = lpc_win_hit(lpc_addr_i, win_base_i, win_mask_i) && en_i;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_i) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= CAP_IDLE;
      ready_prev_q <= 1'b1;
      addr_hit_q   <= 1'b0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      ready_prev_q <= ready_prev_d;
      addr_hit_q   <= addr_hit_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign addr_hit_o = addr_hit_q;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;

  lpc_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr_i),
    .push_i  (push_req),
    .wdata_i (tdata_i),
    .pop_i   (pop),
    .rdata_o (m_tdata_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

endmodule

// File: tb/tb_lpc_cycle_capture_ctrl.sv
// tb/tb_lpc_cycle_capture_ctrl.sv - self-checking bench with queue reference model
module tb_lpc_cycle_capture_ctrl;

  localparam int DEPTH = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic [15:0] win_base_i;
  logic [15:0] win_mask_i;
  logic [15:0] lpc_addr_i;
  logic        addr_hit_o;
  logic [31:0] tdata_i;
  logic        ready_i;
  logic [31:0] m_tdata_o;
  logic        m_tvalid_o;
  logic        m_tready_i;
  logic        clr_i;
  logic [3:0]  level_o;
  logic        overflow_o;
  logic [7:0]  drop_cnt_o;

  always #5 clk_i = ~clk_i;

  lpc_cycle_capture_ctrl #(.DEPTH(DEPTH)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .win_base_i (win_base_i),
    .win_mask_i (win_mask_i),
    .lpc_addr_i (lpc_addr_i),
    .addr_hit_o (addr_hit_o),
    .tdata_i    (tdata_i),
    .ready_i    (ready_i),
    .m_tdata_o  (m_tdata_o),
    .m_tvalid_o (m_tvalid_o),
    .m_tready_i (m_tready_i),
    .clr_i      (clr_i),
    .level_o    (level_o),
    .overflow_o (overflow_o),
    .drop_cnt_o (drop_cnt_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: a queue of records plus the sticky/count state.
  logic [31:0] mq[$];
  bit          m_prev_ready;
  bit          m_ovf;
  int          m_cnt;
  bit          m_hit;

  function automatic logic [31:0] mk(input logic [15:0] a, input logic [7:0] d, input logic [1:0] t);
    return {4'h0, a, d, 2'b00, t};
  endfunction

  function automatic bit in_win(input logic [15:0] a);
    return ((a ^ win_base_i) & win_mask_i) == 16'h0000;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_prev_ready = 1'b1;
    m_ovf = 1'b0;
    m_cnt = 0;
    m_hit = 1'b0;
  endtask

  task automatic model_edge();
    bit fresh, pop, was_full, want;
    fresh        = ready_i && !m_prev_ready;
    m_prev_ready = ready_i;
    m_hit        = in_win(lpc_addr_i) && en_i;
    if (clr_i) begin
      mq.delete();
      m_ovf = 1'b0;
      m_cnt = 0;
    end else begin
      pop      = (mq.size() > 0) && m_tready_i;
      was_full = (mq.size() == DEPTH);
      want     = fresh && en_i && (tdata_i[1:0] != 2'b00) && in_win(tdata_i[27:12]);
      if (pop) void'(mq.pop_front());
      if (want) begin
        if (was_full && !pop) begin
          m_ovf = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end else begin
          mq.push_back(tdata_i);
        end
      end
    end
  endtask

  task automatic check_all();
    check("level", 32'(level_o), 32'(mq.size()));
    check("tvalid", 32'(m_tvalid_o), 32'(mq.size() != 0));
    check("tdata", m_tdata_o, (mq.size() != 0) ? mq[0] : 32'h0);
    check("overflow", 32'(overflow_o), 32'(m_ovf));
    check("drop_cnt", 32'(drop_cnt_o), 32'(m_cnt));
    check("addr_hit", 32'(addr_hit_o), 32'(m_hit));
  endtask

  task automatic cyc();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
    check_all();
  endtask

  task automatic pulse(input logic [31:0] rec, input int hi_cycles);
    tdata_i = rec;
    ready_i = 1'b1;
    repeat (hi_cycles) cyc();
    ready_i = 1'b0;
    cyc();
  endtask

  task automatic fill_rand_window();
    logic [15:0] masks [4];
    masks[0] = 16'hFFF0; masks[1] = 16'hFF00; masks[2] = 16'h0000; masks[3] = 16'($urandom);
    win_base_i = 16'($urandom);
    win_mask_i = masks[$urandom_range(0, 3)];
  endtask

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 3) != 0)
      return (win_base_i & win_mask_i) | (16'($urandom) & ~win_mask_i);
    return 16'($urandom);
  endfunction

  initial begin
    rst_i = 1'b1; en_i = 1'b1; clr_i = 1'b0; ready_i = 1'b0; m_tready_i = 1'b0;
    win_base_i = 16'h0080; win_mask_i = 16'hFFF0; lpc_addr_i = 16'h0000; tdata_i = '0;
    model_reset();
    repeat (2) @(negedge clk_i);
    check("rst_level", 32'(level_o), 32'h0);
    check("rst_tvalid", 32'(m_tvalid_o), 32'h0);
    check("rst_tdata", m_tdata_o, 32'h0);
    rst_i = 1'b0;
    cyc();

    // Single write record captured with one-cycle latency.
    tdata_i = 32'h00080A51; ready_i = 1'b1;
    cyc();
    check("wr_tdata", m_tdata_o, 32'h00080A51);
    check("wr_level", 32'(level_o), 32'h1);
    ready_i = 1'b0;
    m_tready_i = 1'b1; cyc(); m_tready_i = 1'b0;

    // Address hit decode.
    lpc_addr_i = 16'h0090; cyc();
    check("hit_0090", 32'(addr_hit_o), 32'h0);
    lpc_addr_i = 16'h0085; cyc();
    check("hit_0085", 32'(addr_hit_o), 32'h1);
    pulse(mk(16'h0090, 8'h11, 2'b01), 1);
    check("miss_rec", 32'(level_o), 32'h0);

    // Long and short READY pulses, then a type-none record.
    pulse(mk(16'h0081, 8'h22, 2'b11), 2);
    pulse(mk(16'h0082, 8'h33, 2'b01), 1);
    check("two_pulses", 32'(level_o), 32'h2);
    pulse(mk(16'h0083, 8'h44, 2'b00), 1);
    check("type_none", 32'(level_o), 32'h2);
    clr_i = 1'b1; cyc(); clr_i = 1'b0;

    // Nine records into an eight-deep FIFO, then in-order drain.
    for (int i = 1; i <= 9; i++) pulse(mk(16'h0080 + 16'(i), 8'(i), 2'b01), 1);
    check("ovf_level", 32'(level_o), 32'h8);
    check("ovf_flag", 32'(overflow_o), 32'h1);
    check("ovf_cnt", 32'(drop_cnt_o), 32'h1);
    m_tready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("drain_order", m_tdata_o, mk(16'h0080 + 16'(i), 8'(i), 2'b01));
      cyc();
    end
    m_tready_i = 1'b0;
    check("drained", 32'(level_o), 32'h0);

    // Push and pop together while full, then saturating drops, then clear.
    clr_i = 1'b1; cyc(); clr_i = 1'b0;
    for (int i = 0; i < 8; i++) pulse(mk(16'h0084, 8'(i), 2'b11), 1);
    tdata_i = mk(16'h0086, 8'hEE, 2'b01); ready_i = 1'b1; m_tready_i = 1'b1;
    cyc();
    check("pp_level", 32'(level_o), 32'h8);
    check("pp_cnt", 32'(drop_cnt_o), 32'h0);
    ready_i = 1'b0; m_tready_i = 1'b0;
    cyc();
    for (int i = 0; i < 260; i++) pulse(mk(16'h0087, 8'(i), 2'b01), 1);
    check("sat_cnt", 32'(drop_cnt_o), 32'd255);
    clr_i = 1'b1; cyc(); clr_i = 1'b0;
    check("clr_level", 32'(level_o), 32'h0);
    check("clr_ovf", 32'(overflow_o), 32'h0);
    check("clr_cnt", 32'(drop_cnt_o), 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) fill_rand_window();
      en_i       = ($urandom_range(0, 9) != 0);
      clr_i      = ($urandom_range(0, 63) == 0);
      m_tready_i = ($urandom_range(0, 2) == 0);
      ready_i    = $urandom_range(0, 1);
      lpc_addr_i = rand_addr();
      tdata_i    = mk(rand_addr(), 8'($urandom), 2'($urandom));
      cyc();
    end

    // Asynchronous reset with entries held, READY already high at release.
    en_i = 1'b1; clr_i = 1'b0; ready_i = 1'b0; m_tready_i = 1'b0;
    win_base_i = 16'h0080; win_mask_i = 16'hFFF0;
    clr_i = 1'b1; cyc(); clr_i = 1'b0;
    for (int i = 0; i < 3; i++) pulse(mk(16'h0088, 8'(i), 2'b01), 1);
    check("pre_rst_level", 32'(level_o), 32'h3);
    #2 rst_i = 1'b1;
    #1;
    check("async_tvalid", 32'(m_tvalid_o), 32'h0);
    check("async_level", 32'(level_o), 32'h0);
    model_reset();
    tdata_i = mk(16'h0089, 8'h5A, 2'b01); ready_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) cyc();
    check("no_stale_push", 32'(level_o), 32'h0);
    ready_i = 1'b0; cyc();
    ready_i = 1'b1; cyc();
    check("fresh_push", 32'(level_o), 32'h1);
    check("fresh_tdata", m_tdata_o, mk(16'h0089, 8'h5A, 2'b01));
    ready_i = 1'b0; cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lpc_cycle_capture_ctrl.md
# lpc_cycle_capture_ctrl

Controller that sits beside the LPC peripheral. It drives the peripheral's `addr_hit_i` from a programmable I/O address window. It captures each completed cycle record the peripheral publishes on `TDATA`/`READY`, keeping only records that fall inside the window. Captured records are buffered in a FIFO and drained to a downstream consumer over a valid/ready stream, with overflow accounting.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries; power of two, ≥2.

Ports:
- `clk_i`  in  1  LPC clock; one clock domain.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `en_i`  in  1  capture enable; records arriving while low are ignored (not counted as drops).
- `win_base_i`  in  16  window base address.
- `win_mask_i`  in  16  compare mask; bit=1 compares that address bit.
- `lpc_addr_i`  in  16  peripheral address (`lpc_addr_o`).
- `addr_hit_o`  out  1  to peripheral `addr_hit_i`; registered.
- `tdata_i`  in  32  peripheral `TDATA`.
- `ready_i`  in  1  peripheral `READY`; may stay high for 1–2 cycles per record.
- `m_tdata_o`  out  32  head record.
- `m_tvalid_o`  out  1  head record valid.
- `m_tready_i`  in  1  consumer accept.
- `clr_i`  in  1  synchronous flush and counter clear.
- `level_o`  out  $clog2(DEPTH)+1  entries held.
- `overflow_o`  out  1  sticky; set on any drop.
- `drop_cnt_o`  out  8  records dropped due to full; saturates at 255.

## Operation
- Record format, fixed:
  - [31:28]=0.
  - [27:12]=address.
  - [11:4]=data.
  - [3:2]=0.
  - [1:0]=type: 01 write, 11 read, 00 none.
- Window hit: `((addr ^ win_base_i) & win_mask_i) == 0`.
- `addr_hit_o` is registered each cycle as the window hit of `lpc_addr_i`, AND `en_i`.
- Capture FSM, two states:
  - CAP_IDLE: when `ready_i`=1, evaluate the record and go to CAP_HOLD.
  - CAP_HOLD: stay while `ready_i`=1; return to CAP_IDLE when `ready_i`=0.
  - Exactly one evaluation per READY pulse.
- Evaluation pushes `tdata_i` when all of the following hold; otherwise the record is discarded silently:
  - `en_i`=1.
  - type ≠ 00.
  - window hit of `tdata_i[27:12]`.
- Push while full, with no pop in the same cycle: record dropped, `overflow_o`←1, `drop_cnt_o`+1 (saturating).
- Push while full, with a pop in the same cycle: push accepted, level unchanged, no drop.
- FIFO is first-word-fall-through:
  - `m_tvalid_o` = level≠0.
  - `m_tdata_o` = oldest entry.
  - Pop when `m_tvalid_o`&`m_tready_i`.
- Pointers are $clog2(DEPTH)+1 bits and wrap naturally.
  - full: MSBs differ, rest equal.
  - empty: pointers equal.
- `clr_i` empties the FIFO and clears `overflow_o` and `drop_cnt_o`. It has priority over a same-cycle push and pop; that record is neither stored nor counted.
- Reset values:
  - `addr_hit_o`=0, `m_tvalid_o`=0, `m_tdata_o`=0 (mem contents don't care, output qualified), `level_o`=0, `overflow_o`=0, `drop_cnt_o`=0.
  - Capture FSM=CAP_IDLE.
- Reset mid-operation discards all buffered records. The first record after reset release is captured only on a fresh READY rising (FSM in CAP_IDLE, READY sampled high).

## Timing
- `addr_hit_o` lags `lpc_addr_i` by 1 cycle. The peripheral's address is complete two cycles before its TAR_CLK2 sample point, so the hit is valid in time.
- Capture latency: `ready_i` is sampled high at edge N and the write happens at edge N; `m_tvalid_o`=1 and `level_o` update after edge N.
- Pop at edge M: the next entry appears on `m_tdata_o` after edge M. Zero-bubble back-to-back drain.
- `m_tdata_o` must hold stable while `m_tvalid_o`=1 and `m_tready_i`=0.
- `level_o`, `overflow_o` and `drop_cnt_o` update on the same edge as the causing push/pop/clr.

## Structure
- Package `lpc_pkg` holds:
  - record field LSB/width constants;
  - cycle type codes `LPC_CYC_NONE`=00, `LPC_CYC_WR`=01, `LPC_CYC_RD`=11;
  - capture FSM state enum.
- Sub-module `lpc_sync_fifo` provides storage, pointers, full/empty/level, and same-cycle push/pop.
- The top level contains the window compare, capture FSM, drop accounting and `clr_i` handling.

## Test plan
- Write record, win_base 0x0080, mask 0xFFF0: `tdata_i`=0x00080A51 (addr 0x0080, data 0xA5, type 01) → `m_tdata_o`=0x00080A51 one cycle later, `level_o`=1.
- `lpc_addr_i`=0x0090 and `lpc_addr_i`=0x0085 with the same window → `addr_hit_o` 0 and 1 respectively, one cycle later. A record with addr 0x0090 is not pushed.
- `ready_i` held high 2 cycles, then high 1 cycle → exactly 2 entries. A type-00 record → no entry.
- `m_tready_i`=0, DEPTH=8, 9 in-window records → `level_o`=8, `overflow_o`=1, `drop_cnt_o`=1. Draining returns records 1–8 in order.
- Full FIFO, push and pop in the same cycle → `level_o` stays 8, `drop_cnt_o` unchanged. 260 drops → `drop_cnt_o`=255. `clr_i` → all zero.
- `rst_i` asserted asynchronously with `level_o`=3 → `m_tvalid_o`=0 and `level_o`=0 immediately. `ready_i` already high at release → no push until a fresh pulse.
